// File: rtl/scope_grid_timing_gen.sv
// 1080p60 video timing generator with oscilloscope background raster.
// Produces sync/de/data for the waveform overlay stage. The plot window
// has a solid border and an optional solid or dotted graticule. Config
// inputs are shadow-latched once per frame so changes never tear.
module scope_grid_timing_gen #(
   parameter int unsigned H_ACTIVE = 1920,
   parameter int unsigned H_FP     = 88,
   parameter int unsigned H_SYNC   = 44,
   parameter int unsigned H_BP     = 148,
   parameter int unsigned V_ACTIVE = 1080,
   parameter int unsigned V_FP     = 4,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 36,
   parameter logic        HS_POL   = 1'b1,
   parameter logic        VS_POL   = 1'b1,
   parameter int unsigned PLOT_X0  = 442,
   parameter int unsigned PLOT_X1  = 1522,
   parameter int unsigned PLOT_Y0  = 9,
   parameter int unsigned PLOT_Y1  = 1075,
   parameter int unsigned GRID_DX  = 108,
   parameter int unsigned GRID_DY  = 104
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        grid_en,
   input  logic        grid_style,
   input  logic [23:0] bg_color,
   input  logic [23:0] grid_color,
   input  logic [23:0] border_color,
   input  logic [23:0] outer_color,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic [23:0] o_data,
   output logic        o_frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned GXW     = ($clog2(GRID_DX) < 2) ? 2 : $clog2(GRID_DX);
   localparam int unsigned GYW     = ($clog2(GRID_DY) < 2) ? 2 : $clog2(GRID_DY);

   localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0]  HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0]  X0      = HW'(PLOT_X0);
   localparam logic [HW-1:0]  X1      = HW'(PLOT_X1);
   // Column before the window's left edge (wraps when the window starts at 0).
   localparam logic [HW-1:0]  X0_PRE  = HW'((PLOT_X0 + H_TOTAL - 1) % H_TOTAL);
   localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]  V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0]  VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0]  Y0      = VW'(PLOT_Y0);
   localparam logic [VW-1:0]  Y1      = VW'(PLOT_Y1);
   localparam logic [VW-1:0]  Y0_PRE  = VW'((PLOT_Y0 + V_TOTAL - 1) % V_TOTAL);
   localparam logic [GXW-1:0] GX_LAST = GXW'(GRID_DX - 1);
   localparam logic [GYW-1:0] GY_LAST = GYW'(GRID_DY - 1);

   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic [GXW-1:0] gx;
   logic [GYW-1:0] gy;

   logic        s_grid_en;
   logic        s_grid_style;
   logic [23:0] s_bg;
   logic [23:0] s_grid;
   logic [23:0] s_border;
   logic [23:0] s_outer;

   logic        line_end;
   logic        frame_end;
   logic        hs_c;
   logic        vs_c;
   logic        de_c;
   logic        in_win;
   logic        border;
   logic        vline;
   logic        hline;
   logic        grid;
   logic [23:0] pix;

   // Pixel decode: sync windows, plot window membership and colour priority.
   always_comb begin
      line_end  = (h_cnt == H_LAST);
      frame_end = line_end && (v_cnt == V_LAST);
      hs_c      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_c      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      de_c      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      in_win    = (h_cnt >= X0) && (h_cnt <= X1) && (v_cnt >= Y0) && (v_cnt <= Y1);
      border    = in_win && ((h_cnt == X0) || (h_cnt == X1) || (v_cnt == Y0) || (v_cnt == Y1));
      vline     = in_win && (gx == '0) && (!s_grid_style || (gy[1:0] == 2'b00));
      hline     = in_win && (gy == '0) && (!s_grid_style || (gx[1:0] == 2'b00));
      grid      = s_grid_en && (vline || hline);
      pix       = s_outer;
      if (border)
         pix = s_border;
      else if (grid)
         pix = s_grid;
      else if (in_win)
         pix = s_bg;
      if (!de_c)
         pix = '0;
   end

   // Raster and graticule phase counters; gx/gy replace modulo arithmetic.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
         gx    <= '0;
         gy    <= '0;
      end else begin
         h_cnt <= line_end ? '0 : h_cnt + 1'b1;
         if (line_end)
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
         if (h_cnt == X0_PRE)
            gx <= '0;
         else
            gx <= (gx == GX_LAST) ? '0 : gx + 1'b1;
         if (line_end) begin
            if (v_cnt == Y0_PRE)
               gy <= '0;
            else
               gy <= (gy == GY_LAST) ? '0 : gy + 1'b1;
         end
      end
   end

   // Frame-synchronous shadow copy of the configuration inputs.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         s_grid_en    <= 1'b0;
         s_grid_style <= 1'b0;
         s_bg         <= '0;
         s_grid       <= '0;
         s_border     <= '0;
         s_outer      <= '0;
      end else if (frame_end) begin
         s_grid_en    <= grid_en;
         s_grid_style <= grid_style;
         s_bg         <= bg_color;
         s_grid       <= grid_color;
         s_border     <= border_color;
         s_outer      <= outer_color;
      end
   end

   // Output register stage keeping sync, de, data and frame_start aligned.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         o_hs          <= ~HS_POL;
         o_vs          <= ~VS_POL;
         o_de          <= 1'b0;
         o_data        <= '0;
         o_frame_start <= 1'b0;
      end else begin
         o_hs          <= hs_c ? HS_POL : ~HS_POL;
         o_vs          <= vs_c ? VS_POL : ~VS_POL;
         o_de          <= de_c;
         o_data        <= pix;
         o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_scope_grid_timing_gen.sv
// Scoreboard bench for scope_grid_timing_gen on a reduced raster geometry.
// The driver pushes the expected output of every clock edge into a queue,
// computed from absolute pixel index with division/modulo; the monitor pops
// and compares one entry per cycle.
module tb_scope_grid_timing_gen;

   localparam int unsigned HA = 40, HF = 4, HSY = 3, HB = 5;
   localparam int unsigned VA = 20, VF = 2, VSY = 2, VB = 3;
   localparam int unsigned HT = HA + HF + HSY + HB;   // 52
   localparam int unsigned VT = VA + VF + VSY + VB;   // 27
   localparam int unsigned P  = HT * VT;              // cycles per frame
   localparam int unsigned X0 = 5, X1 = 33, Y0 = 2, Y1 = 17;
   localparam int unsigned DX = 7, DY = 5;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        grid_en = 1'b0;
   logic        grid_style = 1'b0;
   logic [23:0] bg_color = '0;
   logic [23:0] grid_color = '0;
   logic [23:0] border_color = '0;
   logic [23:0] outer_color = '0;
   logic        o_hs;
   logic        o_vs;
   logic        o_de;
   logic [23:0] o_data;
   logic        o_frame_start;

   scope_grid_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .PLOT_X0(X0), .PLOT_X1(X1), .PLOT_Y0(Y0), .PLOT_Y1(Y1),
      .GRID_DX(DX), .GRID_DY(DY)
   ) dut (
      .pclk(pclk), .rst_n(rst_n),
      .grid_en(grid_en), .grid_style(grid_style),
      .bg_color(bg_color), .grid_color(grid_color),
      .border_color(border_color), .outer_color(outer_color),
      .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
      .o_frame_start(o_frame_start)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit          en;
      bit          style;
      logic [23:0] bg, gr, bd, ou;
   } cfg_t;

   typedef struct {
      logic [27:0] exp;   // {hs, vs, de, data, frame_start}
      int          pos;   // pixel index within frame, -1 for reset
   } item_t;

   item_t q[$];
   cfg_t  cfg;
   int    n = 0;
   bit    pending_latch = 0;
   bit    running = 1;
   int    compared = 0;
   int    mismatched = 0;

   function automatic logic [27:0] ref_pix(int idx, cfg_t c);
      int x, y, p, gx, gy;
      bit hs, vs, de, win, bord, vl, hl;
      logic [23:0] col;
      p    = idx % P;
      x    = p % HT;
      y    = p / HT;
      hs   = (x >= HA + HF) && (x < HA + HF + HSY);
      vs   = (y >= VA + VF) && (y < VA + VF + VSY);
      de   = (x < HA) && (y < VA);
      win  = (x >= X0) && (x <= X1) && (y >= Y0) && (y <= Y1);
      bord = win && (x == X0 || x == X1 || y == Y0 || y == Y1);
      gx   = win ? (x - X0) % DX : 1;
      gy   = win ? (y - Y0) % DY : 1;
      vl   = win && gx == 0 && (!c.style || gy % 4 == 0);
      hl   = win && gy == 0 && (!c.style || gx % 4 == 0);
      if (bord)                  col = c.bd;
      else if (c.en && (vl || hl)) col = c.gr;
      else if (win)              col = c.bg;
      else                       col = c.ou;
      if (!de) col = '0;
      return {hs, vs, de, col, (p == 0)};
   endfunction

   // One clock of stimulus: inputs set by the caller before this call are
   // those sampled at the coming edge, so a pending frame latch uses them.
   task automatic step(input bit do_rst);
      item_t it;
      if (pending_latch) begin
         cfg.en = grid_en;    cfg.style = grid_style;
         cfg.bg = bg_color;   cfg.gr = grid_color;
         cfg.bd = border_color; cfg.ou = outer_color;
         pending_latch = 0;
      end
      @(negedge pclk);
      rst_n = !do_rst;
      if (do_rst) begin
         it.exp = {1'b0, 1'b0, 1'b0, 24'h0, 1'b0};
         it.pos = -1;
         n = 0;
         cfg = '{default: '0};
      end else begin
         it.exp = ref_pix(n, cfg);
         it.pos = n % P;
         pending_latch = ((n % P) == P - 1);
         n++;
      end
      q.push_back(it);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0);
   endtask

   task automatic set_cfg(input bit en, input bit st, input logic [23:0] bg,
                          input logic [23:0] gr, input logic [23:0] bd,
                          input logic [23:0] ou);
      grid_en = en; grid_style = st; bg_color = bg;
      grid_color = gr; border_color = bd; outer_color = ou;
   endtask

   // Monitor: one registered output per clock, compared against the queue.
   initial begin
      item_t it;
      logic [27:0] act;
      @(negedge pclk);
      forever begin
         @(negedge pclk);
         act = {o_hs, o_vs, o_de, o_data, o_frame_start};
         if (q.size() > 0) begin
            it = q.pop_front();
            compared++;
            if (act !== it.exp) begin
               mismatched++;
               $display("FAIL pixel pos=%0d (x=%0d y=%0d) got hs/vs/de/data/fs=%b/%b/%b/%h/%b expected %b/%b/%b/%h/%b",
                        it.pos, (it.pos < 0) ? -1 : it.pos % HT, (it.pos < 0) ? -1 : it.pos / HT,
                        act[27], act[26], act[25], act[24:1], act[0],
                        it.exp[27], it.exp[26], it.exp[25], it.exp[24:1], it.exp[0]);
            end
         end else if (running) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty got no expected entry, required one per cycle");
         end
      end
   end

   initial begin
      cfg = '{default: '0};
      step(1'b1); step(1'b1); step(1'b1);
      // Frame 0 uses zeroed shadow config; solid grid latched for frame 1.
      set_cfg(1'b1, 1'b0, 24'h000000, 24'h404040, 24'hFFFFFF, 24'h101010);
      run(P);
      // Mid-frame colour change only shows up in the next frame.
      run(10 * HT);
      grid_color = 24'hFF0000;
      run(P - 10 * HT);
      // Dotted style for frame 3.
      grid_style = 1'b1;
      run(P);
      // Graticule removed for frame 4, border remains.
      grid_en = 1'b0;
      run(P);
      // One-cycle reset mid-frame, then zeroed config for the first frame.
      run(12 * HT + 30);
      set_cfg(1'b1, 1'b0, 24'h0000AA, 24'h00FF00, 24'hFFFF00, 24'h123456);
      step(1'b1);
      run(P + P / 2);
      // Random config changes at random moments.
      for (int i = 0; i < 3 * P; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            case ($urandom_range(0, 5))
               0: grid_en = 1'($urandom);
               1: grid_style = 1'($urandom);
               2: bg_color = 24'($urandom);
               3: grid_color = 24'($urandom);
               4: border_color = 24'($urandom);
               default: outer_color = 24'($urandom);
            endcase
         end
         step(1'b0);
      end
      @(negedge pclk);
      running = 0;
      @(negedge pclk);
      @(negedge pclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
